// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline register chain.
package pipe_pkg;
    localparam int STALL_CNT_W       = 32;
    localparam int RESET_VAL_DEFAULT = 0;

    function automatic int OCC_W(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/elastic_pipe_stage.sv
// One valid/data register pair of the elastic chain; loads its upstream neighbour on Adv.
module elastic_pipe_stage #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Flush,
    input  logic             Adv,
    input  logic             In_Valid,
    input  logic [WIDTH-1:0] In_Data,
    output logic             Valid,
    output logic             Valid_Next,
    output logic [WIDTH-1:0] Data
);
    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;

    // Data only moves with a real word, so an empty advance keeps the old payload.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (Flush) begin
            valid_d = 1'b0;
        end else if (Adv) begin
            valid_d = In_Valid;
            if (In_Valid) begin
                data_d = In_Data;
            end else begin
                data_d = data_q;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign Valid      = valid_q;
    assign Valid_Next = valid_d;
    assign Data       = data_q;
endmodule

// File: rtl/elastic_pipe_reg.sv
// DEPTH-stage valid/ready pipeline register with bubble collapsing and flush.
// Optional stall counter enabled by defining ELASTIC_PIPE_STALL_CNT_EN.
module elastic_pipe_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_VAL_DEFAULT)
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      Flush,
    input  logic                      In_Valid,
    input  logic [WIDTH-1:0]          In_Data,
    output logic                      In_Ready,
    output logic                      Out_Valid,
    output logic [WIDTH-1:0]          Out_Data,
    input  logic                      Out_Ready,
    output logic [OCC_W(DEPTH)-1:0]   Occupancy,
    output logic [STALL_CNT_W-1:0]    Stall_Count
);
    localparam int OW = OCC_W(DEPTH);

    logic [DEPTH-1:0] v, v_nxt, adv;
    logic [WIDTH-1:0] d [DEPTH];
    logic             in_ready;
    logic [OW-1:0]    occ_d, occ_q;

    // A stage may advance if anything downstream of it can move or it is empty.
    always_comb begin
        adv            = '0;
        adv[DEPTH-1]   = Out_Ready | ~v[DEPTH-1];
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = adv[i+1] | ~v[i];
        end
    end

    assign in_ready = adv[0] & ~Flush;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic             src_valid;
        logic [WIDTH-1:0] src_data;
        if (g == 0) begin : g_head
            assign src_valid = In_Valid & in_ready;
            assign src_data  = In_Data;
        end else begin : g_body
            assign src_valid = v[g-1];
            assign src_data  = d[g-1];
        end
        elastic_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .Clk        (Clk),
            .Rst        (Rst),
            .Flush      (Flush),
            .Adv        (adv[g]),
            .In_Valid   (src_valid),
            .In_Data    (src_data),
            .Valid      (v[g]),
            .Valid_Next (v_nxt[g]),
            .Data       (d[g])
        );
    end

    always_comb begin
        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + OW'(v_nxt[i]);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

`ifdef ELASTIC_PIPE_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_d, stall_q;

    // Saturating count of edges where the output word is held back.
    always_comb begin
        stall_d = stall_q;
        if (v[DEPTH-1] & ~Out_Ready & ~Flush & (stall_q != {STALL_CNT_W{1'b1}})) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end else begin
            stall_d = stall_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign Stall_Count = stall_q;
`else
    assign Stall_Count = '0;
`endif

    assign In_Ready  = in_ready;
    assign Out_Valid = v[DEPTH-1];
    assign Out_Data  = d[DEPTH-1];
    assign Occupancy = occ_q;
endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Self-checking bench for elastic_pipe_reg: vector table, corner sequences and random traffic
// against a word-position model of the chain.
module tb_elastic_pipe_reg;
    localparam int          W  = 32;
    localparam int          D  = 2;
    localparam logic [31:0] RV = 32'h5;
`ifdef ELASTIC_PIPE_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Rst, Flush, In_Valid, Out_Ready;
    logic [W-1:0]  In_Data;
    logic          In_Ready, Out_Valid;
    logic [W-1:0]  Out_Data;
    logic [1:0]    Occupancy;
    logic [31:0]   Stall_Count;

    int n_checks = 0;
    int n_err    = 0;

    elastic_pipe_reg #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
        .Clk(Clk), .Rst(Rst), .Flush(Flush), .In_Valid(In_Valid), .In_Data(In_Data),
        .In_Ready(In_Ready), .Out_Valid(Out_Valid), .Out_Data(Out_Data),
        .Out_Ready(Out_Ready), .Occupancy(Occupancy), .Stall_Count(Stall_Count)
    );

    always #5 Clk = ~Clk;

    // Model: ordered words, each with its stage position; words slide forward unless blocked.
    typedef struct { logic [31:0] data; int pos; } word_t;
    word_t       mq[$];
    logic [31:0] m_out   = RV;
    logic [31:0] m_stall = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic fl, input logic iv, input logic [31:0] id,
                              input logic ordy, output logic rdy, output logic popped,
                              output logic [31:0] pdata);
        int limit;
        rdy = 1'b0; popped = 1'b0; pdata = 32'h0;
        if (rst) begin
            mq.delete(); m_out = RV; m_stall = 32'h0;
            return;
        end
        if (fl) begin
            mq.delete();
            return;
        end
        if (mq.size() > 0 && mq[0].pos == D - 1) begin
            if (ordy) begin
                popped = 1'b1; pdata = mq[0].data;
                void'(mq.pop_front());
            end else if (STALL_EN && m_stall != 32'hFFFF_FFFF) begin
                m_stall = m_stall + 32'd1;
            end
        end
        limit = D;
        foreach (mq[k]) begin
            int np;
            np = (mq[k].pos + 1 < limit) ? mq[k].pos + 1 : limit - 1;
            if (np == D - 1 && mq[k].pos != D - 1) m_out = mq[k].data;
            mq[k].pos = np;
            limit = np;
        end
        rdy = (mq.size() == 0) || (mq[mq.size()-1].pos >= 1);
        if (rdy && iv) begin
            mq.push_back('{data: id, pos: 0});
            if (D == 1) m_out = id;
        end
    endtask

    // One clock cycle: drive at negedge, capture pre-edge outputs, step model, check after edge.
    task automatic cyc(input logic rst, input logic fl, input logic iv, input logic [31:0] id,
                       input logic ordy, output logic rdy_dut);
        logic        rdy_exp, popped;
        logic [31:0] pdata, od_pre;
        logic        exp_ov;
        @(negedge Clk);
        Rst = rst; Flush = fl; In_Valid = iv; In_Data = id; Out_Ready = ordy;
        #1;
        rdy_dut = In_Ready;
        od_pre  = Out_Data;
        @(posedge Clk);
        model_edge(rst, fl, iv, id, ordy, rdy_exp, popped, pdata);
        #1;
        if (!rst) chk("in_ready", {31'h0, rdy_dut}, {31'h0, rdy_exp});
        if (popped) chk("deliver_data", od_pre, pdata);
        exp_ov = (mq.size() > 0) && (mq[0].pos == D - 1);
        chk("out_valid", {31'h0, Out_Valid}, {31'h0, exp_ov});
        chk("out_data", Out_Data, m_out);
        chk("occupancy", {30'h0, Occupancy}, 32'(mq.size()));
        chk("stall_count", Stall_Count, m_stall);
    endtask

    typedef struct {
        logic fl; logic iv; logic [31:0] id; logic ordy;
        logic exp_rdy; logic exp_ov; logic [31:0] exp_od; logic [1:0] exp_occ;
    } vec_t;
    vec_t vt[11];

    initial begin
        logic r;
        int   acc;
        Rst = 1'b1; Flush = 1'b0; In_Valid = 1'b0; In_Data = 32'h0; Out_Ready = 1'b0;

        // fl iv id ordy | rdy ov od occ   (reset leaves Out_Data = 5)
        vt[0]  = '{1'b0, 1'b1, 32'h11,   1'b1, 1'b1, 1'b0, 32'h5,  2'd1};
        vt[1]  = '{1'b0, 1'b1, 32'h22,   1'b1, 1'b1, 1'b1, 32'h11, 2'd2};
        vt[2]  = '{1'b0, 1'b1, 32'h33,   1'b1, 1'b1, 1'b1, 32'h22, 2'd2};
        vt[3]  = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 32'h33, 2'd1};
        vt[4]  = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 32'h33, 2'd0};
        vt[5]  = '{1'b0, 1'b1, 32'hA0,   1'b0, 1'b1, 1'b0, 32'h33, 2'd1};
        vt[6]  = '{1'b0, 1'b1, 32'hA1,   1'b0, 1'b1, 1'b1, 32'hA0, 2'd2};
        vt[7]  = '{1'b0, 1'b1, 32'hA2,   1'b0, 1'b0, 1'b1, 32'hA0, 2'd2};
        vt[8]  = '{1'b0, 1'b1, 32'hA2,   1'b0, 1'b0, 1'b1, 32'hA0, 2'd2};
        vt[9]  = '{1'b1, 1'b1, 32'hBEEF, 1'b1, 1'b0, 1'b0, 32'hA0, 2'd0};
        vt[10] = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 32'hA0, 2'd0};

        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, r);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, r);
        chk("rst_out_data", Out_Data, RV);
        chk("rst_out_valid", {31'h0, Out_Valid}, 32'h0);
        chk("rst_occupancy", {30'h0, Occupancy}, 32'h0);

        for (int i = 0; i < 11; i++) begin
            cyc(1'b0, vt[i].fl, vt[i].iv, vt[i].id, vt[i].ordy, r);
            chk($sformatf("vec%0d_rdy", i), {31'h0, r}, {31'h0, vt[i].exp_rdy});
            chk($sformatf("vec%0d_ov", i), {31'h0, Out_Valid}, {31'h0, vt[i].exp_ov});
            chk($sformatf("vec%0d_od", i), Out_Data, vt[i].exp_od);
            chk($sformatf("vec%0d_occ", i), {30'h0, Occupancy}, {30'h0, vt[i].exp_occ});
        end

        // Back-pressure: only two words fit, then drain in order
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 32'hC0 + 32'(i), 1'b0, r);
            acc += int'(r);
        end
        chk("bp_accepted", 32'(acc), 32'd2);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, r);
        chk("bp_drain0", Out_Data, 32'hC1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, r);
        chk("bp_drain_empty", {31'h0, Out_Valid}, 32'h0);

        // Full chain, simultaneous in/out for 4 cycles
        cyc(1'b0, 1'b0, 1'b1, 32'hD0, 1'b0, r);
        cyc(1'b0, 1'b0, 1'b1, 32'hD1, 1'b0, r);
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 32'hE0 + 32'(i), 1'b1, r);
            acc += int'(r);
            chk("full_occ", {30'h0, Occupancy}, 32'd2);
        end
        chk("full_accepted", 32'(acc), 32'd4);

        // Reset mid-stream
        cyc(1'b1, 1'b0, 1'b1, 32'hF0, 1'b1, r);
        chk("midrst_ov", {31'h0, Out_Valid}, 32'h0);
        chk("midrst_od", Out_Data, RV);
        chk("midrst_occ", {30'h0, Occupancy}, 32'h0);
        chk("midrst_stall", Stall_Count, 32'h0);

        // Seven held cycles on a valid output
        cyc(1'b0, 1'b0, 1'b1, 32'h71, 1'b0, r);
        cyc(1'b0, 1'b0, 1'b1, 32'h72, 1'b0, r);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, r);
        chk("stall7", Stall_Count, STALL_EN ? 32'd7 : 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 3) != 0), $urandom, $urandom_range(0, 1) == 1, r);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
